if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single pipeline clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 flush  in  1  pipeline flush from ID/CP0 (exception, eret, taken redirect).
REQ-006 in_valid  in  1  IF presents a fetched instruction (IF-to-queue valid).
REQ-007 in_pc  in  32  PC of the fetched instruction.
REQ-008 in_instr  in  32  fetched instruction word.
REQ-009 q_allowin  out  1  queue can accept an entry this cycle; drives IF's downstream allowin.
REQ-010 id_allowin  in  1  ID can accept an instruction this cycle.
REQ-011 q_validto  out  1  head entry valid toward ID (queue-to-ID valid).
REQ-012 out_pc  out  32  PC of the head entry.
REQ-013 out_instr  out  32  instruction word of the head entry.
REQ-014 count  out  AW+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 Push SHALL occur when in_valid && q_allowin && !flush; the entry {in_pc, in_instr} is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
REQ-016 Pop SHALL occur when q_validto && id_allowin && !flush; rd_ptr advances by 1 modulo DEPTH.
REQ-017 q_allowin SHALL be combinational: (count != DEPTH) || id_allowin. A full queue SHALL therefore accept a push in the same cycle as a pop.
REQ-018 q_validto SHALL equal (count != 0); it SHALL NOT depend combinationally on in_valid. There is no bypass from input to output.
REQ-019 out_pc and out_instr SHALL show the entry at rd_ptr (show-ahead). Both SHALL read 0 when count == 0.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on the outputs, with q_validto=1, after edge N if the queue was empty.
REQ-021 count update: push only, +1; pop only, -1; push and pop together, unchanged; neither, unchanged. count SHALL never exceed DEPTH or go below 0.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble and no data corruption.
REQ-023 Entries SHALL leave in strict FIFO order; no entry is dropped or duplicated except by flush or rst.
REQ-024 On flush at an edge, rd_ptr, wr_ptr and count SHALL become 0, and any push or pop in that cycle SHALL be discarded. After that edge, q_validto=0 and q_allowin=1.
REQ-025 If flush and in_valid are both asserted, the presented instruction SHALL be dropped; the first post-flush push SHALL come from the next cycle.
REQ-026 If in_valid=1 while q_allowin=0, the queue SHALL leave its state unchanged; IF holds its instruction.
REQ-027 Held outputs SHALL remain stable while q_validto=1 and id_allowin=0, unless a flush occurs.
REQ-028 Storage array contents SHALL only change on a push (rst and flush need not clear storage).

Reset
REQ-029 When rst=1 at an edge: rd_ptr=0, wr_ptr=0, count=0; hence q_validto=0, out_pc=0, out_instr=0, q_allowin=1.
REQ-030 rst SHALL take priority over flush, push and pop. A rst asserted mid-operation SHALL discard all entries within one edge.

Verification
REQ-031 Fill/drain: id_allowin=0; push PCs 0x00400000, 0x00400004, 0x00400008, 0x0040000C. Required: count=4, and q_allowin=0. Then id_allowin=1 and in_valid=0. Required: the four PCs appear in order on four consecutive edges, and count returns to 0.
REQ-032 Full pass-through: queue full, in_valid=1 and id_allowin=1 for 8 cycles with incrementing PCs. Required: count stays 4, one pop and one push per cycle, and PC order is preserved across pointer wrap.
REQ-033 Flush with traffic: 3 entries held, then flush=1 with in_valid=1 and in_pc=0x00400100. Required: next cycle count=0, q_validto=0, and 0x00400100 never appears on out_pc.
REQ-034 Stall hold: 1 entry at 0x00400020, id_allowin=0 for 5 cycles. Required: out_pc=0x00400020 and q_validto=1 on every cycle.
REQ-035 Reset mid-stream: 2 entries held, then rst=1 for one cycle with in_valid=1. Required: count=0, out_pc=0, out_instr=0, and q_allowin=1 after the edge.
REQ-036 Empty latency: push 0x00400040 into an empty queue at edge N with id_allowin=1. Required: q_validto=0 before edge N, q_validto=1 after it, and the pop occurs at edge N+1.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Handshake bundle between IF, the fetch queue and ID.
// The queue uses the slave view; the IF/ID side (or a bench) uses the master view.
interface if_fetch_queue_if #(
    parameter int AW = 2
);
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        q_allowin;
    logic        id_allowin;
    logic        q_validto;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [AW:0] count;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, id_allowin,
        output q_allowin, q_validto, out_pc, out_instr, count
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, id_allowin,
        input  q_allowin, q_validto, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Show-ahead instruction fetch queue between IF and ID, with flush.
// No input-to-output bypass: an entry is visible only after the edge that writes it.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.slave   fq
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          valid;
    logic          allowin;
    logic          push;
    logic          pop;

    // A full queue still accepts when ID drains the head in the same cycle.
    assign valid   = (count_q != '0);
    assign allowin = (count_q != DEPTH_C) || fq.id_allowin;
    assign push    = fq.in_valid && allowin && !fq.flush;
    assign pop     = valid && fq.id_allowin && !fq.flush;

    assign fq.q_allowin = allowin;
    assign fq.q_validto = valid;
    assign fq.count     = count_q;
    assign fq.out_pc    = valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign fq.out_instr = valid ? instr_mem_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared by rst/flush; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wr_ptr_q]    <= fq.in_pc;
            instr_mem_q[wr_ptr_q] <= fq.in_instr;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a occupancy/queue reference model fed at posedge,
// a negedge monitor that checks state and pops expected entries on every DUT handoff.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cnt = 0;
    bit   m_push, m_pop;
    ent_t exp_q [$];

    if_fetch_queue_if #(.AW(AW)) fq ();

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: occupancy count plus FIFO of accepted entries.
    always @(posedge clk) begin
        if (rst || fq.flush) begin
            cnt = 0;
            exp_q.delete();
        end else begin
            m_pop  = (cnt > 0) && fq.id_allowin;
            m_push = fq.in_valid && ((cnt < DEPTH) || fq.id_allowin);
            if (m_push) exp_q.push_back('{fq.in_pc, fq.in_instr});
            cnt = cnt + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: state checks each cycle, and scoreboard pop on every handoff to ID.
    always @(negedge clk) begin
        ent_t e;
        chk("count", 32'(fq.count), 32'(cnt));
        chk("q_validto", 32'(fq.q_validto), 32'(cnt != 0));
        chk("q_allowin", 32'(fq.q_allowin), 32'((cnt != DEPTH) || fq.id_allowin));
        if (cnt == 0) begin
            chk("empty_out_pc", fq.out_pc, 32'h0);
            chk("empty_out_instr", fq.out_instr, 32'h0);
        end else if (!fq.id_allowin && exp_q.size() > 0) begin
            chk("held_pc", fq.out_pc, exp_q[0].pc);
        end
        if (fq.q_validto && fq.id_allowin && !fq.flush && !rst) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_underflow: got pc %h expected no entry (t=%0t)", fq.out_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", fq.out_pc, e.pc);
                chk("pop_instr", fq.out_instr, e.instr);
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] pc, input logic ida);
        rst           = r;
        fq.flush      = f;
        fq.in_valid   = v;
        fq.in_pc      = pc;
        fq.in_instr   = ins(pc);
        fq.id_allowin = ida;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0, 32'h0, 1);
        cyc(1, 0, 0, 32'h0, 1);

        // Fill to full with ID stalled, try one more push, then drain in order.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h0040_0000 + 32'(4*i), 0);
        cyc(0, 0, 1, 32'h0040_0010, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 1);

        // Full pass-through across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h0040_0200 + 32'(4*i), 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'h0040_0210 + 32'(4*i), 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 1);

        // Flush with an instruction presented in the same cycle.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h0040_0080 + 32'(4*i), 0);
        cyc(0, 1, 1, 32'h0040_0100, 0);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);

        // Stall hold on a single entry.
        cyc(0, 0, 1, 32'h0040_0020, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);

        // Reset mid-stream with a push pending.
        cyc(0, 0, 1, 32'h0040_0300, 0);
        cyc(0, 0, 1, 32'h0040_0304, 0);
        cyc(1, 0, 1, 32'h0040_0308, 0);
        cyc(0, 0, 0, 32'h0, 1);

        // Empty-queue latency: visible after the push edge, popped on the next.
        cyc(0, 0, 1, 32'h0040_0040, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), ($urandom & 32'hFFFF_FFFC),
                ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
